// File: rtl/redundant_vote_ctrl.sv
// -----------------------------------------------------------------------------
// redundant_vote_ctrl
//
// N-way redundancy voter placed between N replicated cipher cores and the
// system output. A run starts from IDLE, collects one result word from every
// replica (or gives up after TIMEOUT cycles), performs a word-level majority
// vote and publishes the agreed word, or FAULT_CONST when no majority exists.
// Faulty runs are counted; reaching FAULT_LIMIT locks the block into an alarm
// state that only reset leaves.
//
// Parameters
//   W           width of each replica result word
//   N           replica count (3..8)
//   TIMEOUT     maximum number of cycles spent waiting for replicas (>= 2)
//   FAULT_LIMIT number of faulty runs that triggers lockout (1..255)
//   FAULT_CONST word published on an unresolved vote and while locked
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   start_i        begin a vote run (only honoured in IDLE)
//   rep_data_i     replica i word at [i*W +: W]
//   rep_ready_i    replica i result valid (level)
//   out_data_o     voted word or FAULT_CONST
//   out_valid_o    one-cycle pulse marking a fresh vote result
//   fault_o        run had a disagreement or a missing replica
//   agree_mask_o   bit i set when replica i was captured and equals the winner
//   fault_count_o  saturating count of faulty runs since reset
//   alarm_o        sticky lockout flag
// -----------------------------------------------------------------------------
module redundant_vote_ctrl #(
   parameter int           W           = 128,
   parameter int           N           = 3,
   parameter int           TIMEOUT     = 64,
   parameter int           FAULT_LIMIT = 4,
   parameter logic [127:0] FAULT_CONST = 128'h8C784
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           start_i,
   input  logic [N*W-1:0] rep_data_i,
   input  logic [N-1:0]   rep_ready_i,
   output logic [W-1:0]   out_data_o,
   output logic           out_valid_o,
   output logic           fault_o,
   output logic [N-1:0]   agree_mask_o,
   output logic [7:0]     fault_count_o,
   output logic           alarm_o
);

   localparam int             TW         = $clog2(TIMEOUT);
   localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);
   localparam logic [3:0]     MAJORITY   = 4'(N / 2 + 1);
   localparam logic [7:0]     LIMIT      = 8'(FAULT_LIMIT);
   // Size cast truncates or zero-extends the constant to the word width.
   localparam logic [W-1:0]   FAULT_WORD = W'(FAULT_CONST);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_VOTE = 2'd2,
      S_LOCK = 2'd3
   } state_t;

   // Fault counter increments but never wraps past 255.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   state_t          state_q,       state_d;
   logic [N-1:0]    cap_flags_q,   cap_flags_d;
   logic [TW-1:0]   timer_q,       timer_d;
   logic [W-1:0]    out_data_q,    out_data_d;
   logic            out_valid_q,   out_valid_d;
   logic            fault_q,       fault_d;
   logic [N-1:0]    agree_mask_q,  agree_mask_d;
   logic [7:0]      fault_count_q, fault_count_d;
   logic            alarm_q,       alarm_d;

   // Captured replica words; only meaningful where the matching flag is set.
   logic [W-1:0]    cap_reg_q [N];
   logic [N-1:0]    cap_en;

   logic [3:0]      match_cnt [N];
   logic            win_found;
   logic [W-1:0]    win_word;
   logic [N-1:0]    vote_mask;

   // --------------------------------------------------------------------------
   // Majority vote over the captured words. Uncaptured replicas neither score
   // nor count towards anyone else's score.
   // --------------------------------------------------------------------------
   always_comb begin
      win_found = 1'b0;
      win_word  = '0;
      vote_mask = '0;
      for (int i = 0; i < N; i++) begin
         match_cnt[i] = 4'd0;
         if (cap_flags_q[i]) begin
            for (int j = 0; j < N; j++) begin
               if (cap_flags_q[j] && (cap_reg_q[j] == cap_reg_q[i])) begin
                  match_cnt[i] = match_cnt[i] + 4'd1;
               end
            end
         end
      end
      // Lowest-index replica holding a strict majority wins.
      for (int i = 0; i < N; i++) begin
         if (!win_found && (match_cnt[i] >= MAJORITY)) begin
            win_found = 1'b1;
            win_word  = cap_reg_q[i];
         end
      end
      for (int j = 0; j < N; j++) begin
         vote_mask[j] = win_found && cap_flags_q[j] && (cap_reg_q[j] == win_word);
      end
   end

   // --------------------------------------------------------------------------
   // Next-state and output logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      cap_flags_d   = cap_flags_q;
      timer_d       = timer_q;
      out_data_d    = out_data_q;
      out_valid_d   = 1'b0;
      fault_d       = fault_q;
      agree_mask_d  = agree_mask_q;
      fault_count_d = fault_count_q;
      alarm_d       = alarm_q;
      cap_en        = '0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d     = S_WAIT;
               cap_flags_d = '0;
               timer_d     = '0;
            end
         end

         S_WAIT: begin
            // A replica is captured once; later data from it is ignored.
            cap_en      = rep_ready_i & ~cap_flags_q;
            cap_flags_d = cap_flags_q | cap_en;
            timer_d     = timer_q + TW'(1);
            // Captures in the final wait cycle still count since the vote
            // reads the flags one cycle later.
            if ((&cap_flags_d) || (timer_q == TIMER_LAST)) begin
               state_d = S_VOTE;
            end
         end

         S_VOTE: begin
            out_valid_d  = 1'b1;
            out_data_d   = win_found ? win_word : FAULT_WORD;
            agree_mask_d = vote_mask;
            fault_d      = ~(&vote_mask);
            if (fault_d) begin
               fault_count_d = sat_inc(fault_count_q);
            end
            // Alarm rises together with the result of the run that hit the
            // limit; that result is still published unmodified.
            if (fault_count_d >= LIMIT) begin
               state_d = S_LOCK;
               alarm_d = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_LOCK: begin
            out_data_d = FAULT_WORD;
            alarm_d    = 1'b1;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // State and output registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         cap_flags_q   <= '0;
         timer_q       <= '0;
         out_data_q    <= '0;
         out_valid_q   <= 1'b0;
         fault_q       <= 1'b0;
         agree_mask_q  <= '0;
         fault_count_q <= 8'd0;
         alarm_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         cap_flags_q   <= cap_flags_d;
         timer_q       <= timer_d;
         out_data_q    <= out_data_d;
         out_valid_q   <= out_valid_d;
         fault_q       <= fault_d;
         agree_mask_q  <= agree_mask_d;
         fault_count_q <= fault_count_d;
         alarm_q       <= alarm_d;
      end
   end

   // --------------------------------------------------------------------------
   // Replica capture registers; validity is tracked by cap_flags_q, so these
   // need no reset.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < N; i++) begin
         if (cap_en[i]) begin
            cap_reg_q[i] <= rep_data_i[i*W +: W];
         end
      end
   end

   assign out_data_o    = out_data_q;
   assign out_valid_o   = out_valid_q;
   assign fault_o       = fault_q;
   assign agree_mask_o  = agree_mask_q;
   assign fault_count_o = fault_count_q;
   assign alarm_o       = alarm_q;

endmodule

// File: tb/tb_redundant_vote_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for redundant_vote_ctrl (N=3, TIMEOUT=64, FAULT_LIMIT=2).
// Stimulus pushes expected results into a queue; a monitor on the falling
// edge pops and compares whenever out_valid is seen.
// -----------------------------------------------------------------------------
module tb_redundant_vote_ctrl;

   localparam int           W           = 128;
   localparam int           N           = 3;
   localparam int           TIMEOUT     = 64;
   localparam int           FAULT_LIMIT = 2;
   localparam logic [127:0] FC          = 128'h8C784;
   localparam logic [127:0] A5          = {16{8'hA5}};

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [N*W-1:0] rep_data;
   logic [N-1:0]   rep_ready;
   logic [W-1:0]   out_data;
   logic           out_valid;
   logic           fault;
   logic [N-1:0]   agree_mask;
   logic [7:0]     fault_count;
   logic           alarm;

   redundant_vote_ctrl #(
      .W           (W),
      .N           (N),
      .TIMEOUT     (TIMEOUT),
      .FAULT_LIMIT (FAULT_LIMIT),
      .FAULT_CONST (FC)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .start_i       (start),
      .rep_data_i    (rep_data),
      .rep_ready_i   (rep_ready),
      .out_data_o    (out_data),
      .out_valid_o   (out_valid),
      .fault_o       (fault),
      .agree_mask_o  (agree_mask),
      .fault_count_o (fault_count),
      .alarm_o       (alarm)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;
   int n_valid  = 0;

   typedef struct {
      logic [127:0] data;
      logic         flt;
      logic [2:0]   mask;
      logic [7:0]   cnt;
      logic         alm;
      int           cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [127:0] d, input logic f, input logic [2:0] m,
                           input logic [7:0] c, input logic a, input int at);
      exp_t e;
      e.data = d; e.flt = f; e.mask = m; e.cnt = c; e.alm = a; e.cyc = at;
      sb.push_back(e);
   endtask

   task automatic wait_drain(input string name, input int budget);
      int k = 0;
      while (sb.size() != 0 && k < budget) begin
         tick();
         k++;
      end
      chk(name, 128'(sb.size()), 128'd0);
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // One run where all replicas present at start+1 with the given words.
   task automatic run_all(input logic [127:0] w0, input logic [127:0] w1, input logic [127:0] w2);
      start    = 1'b1;
      rep_data = {w2, w1, w0};
      tick();
      start     = 1'b0;
      rep_ready = 3'b111;
      tick();
      rep_ready = 3'b000;
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         n_valid++;
         if (sb.size() == 0) begin
            chk("unexpected_out_valid", 128'd1, 128'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("out_cycle",   128'(cyc),         128'(mon_e.cyc));
            chk("out_data",    out_data,          mon_e.data);
            chk("fault",       128'(fault),       128'(mon_e.flt));
            chk("agree_mask",  128'(agree_mask),  128'(mon_e.mask));
            chk("fault_count", 128'(fault_count), 128'(mon_e.cnt));
            chk("alarm",       128'(alarm),       128'(mon_e.alm));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int snap;

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      rep_data  = '0;
      rep_ready = '0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      chk("rst_out_data",    out_data,          128'd0);
      chk("rst_out_valid",   128'(out_valid),   128'd0);
      chk("rst_fault",       128'(fault),       128'd0);
      chk("rst_agree_mask",  128'(agree_mask),  128'd0);
      chk("rst_fault_count", 128'(fault_count), 128'd0);
      chk("rst_alarm",       128'(alarm),       128'd0);
      tick();

      // All agree, minimum latency
      push_exp(A5, 1'b0, 3'b111, 8'd0, 1'b0, cyc + 3);
      run_all(A5, A5, A5);
      wait_drain("drain_agree", 20);
      tick();

      // Replica 1 disagrees, staggered readies at +1/+5/+9
      push_exp(128'h2, 1'b1, 3'b101, 8'd1, 1'b0, cyc + 11);
      start    = 1'b1;
      rep_data = {128'h2, 128'h1, 128'h2};
      tick();
      start     = 1'b0;
      rep_ready = 3'b001;
      repeat (4) tick();
      rep_ready = 3'b011;
      repeat (4) tick();
      rep_ready = 3'b111;
      tick();
      rep_ready = 3'b000;
      wait_drain("drain_stagger", 20);
      // Results hold after the pulse
      tick();
      tick();
      chk("hold_out_data",  out_data,         128'h2);
      chk("hold_out_valid", 128'(out_valid),  128'd0);
      chk("hold_mask",      128'(agree_mask), 128'(3'b101));

      // All distinct: no majority
      pulse_rst();
      push_exp(FC, 1'b1, 3'b000, 8'd1, 1'b0, cyc + 3);
      run_all(128'h1, 128'h2, 128'h3);
      wait_drain("drain_distinct", 20);
      tick();

      // Replica 2 never ready: timeout path
      pulse_rst();
      push_exp(128'h7, 1'b1, 3'b011, 8'd1, 1'b0, cyc + TIMEOUT + 2);
      start    = 1'b1;
      rep_data = {128'h9, 128'h7, 128'h7};
      tick();
      start     = 1'b0;
      rep_ready = 3'b011;
      wait_drain("drain_timeout", TIMEOUT + 20);
      rep_ready = 3'b000;
      tick();

      // Second faulty run reaches FAULT_LIMIT: alarm with the result
      push_exp(128'h5, 1'b1, 3'b011, 8'd2, 1'b1, cyc + 3);
      run_all(128'h5, 128'h5, 128'h6);
      wait_drain("drain_lockrun", 20);
      tick();
      chk("lock_out_data", out_data,      FC);
      chk("lock_alarm",    128'(alarm),   128'd1);
      // Start in LOCK is ignored
      snap = n_valid;
      run_all(A5, A5, A5);
      repeat (10) tick();
      chk("lock_no_valid",    128'(n_valid),     128'(snap));
      chk("lock_out_data2",   out_data,          FC);
      chk("lock_alarm2",      128'(alarm),       128'd1);
      chk("lock_fault_count", 128'(fault_count), 128'd2);
      pulse_rst();
      chk("unlock_alarm",       128'(alarm),       128'd0);
      chk("unlock_fault_count", 128'(fault_count), 128'd0);
      chk("unlock_out_data",    out_data,          128'd0);
      tick();

      // Reset during WAIT aborts the run
      snap     = n_valid;
      start    = 1'b1;
      rep_data = {A5, A5, A5};
      tick();
      start     = 1'b0;
      rep_ready = 3'b001;
      tick();
      rep_ready = 3'b000;
      pulse_rst();
      repeat (6) tick();
      chk("abort_no_valid", 128'(n_valid), 128'(snap));
      push_exp(A5, 1'b0, 3'b111, 8'd0, 1'b0, cyc + 3);
      run_all(A5, A5, A5);
      wait_drain("drain_after_abort", 20);
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
